// File: rtl/dmem_subsystem.sv
// dmem_subsystem: 24-bit core data memory, RAM plus memory-mapped IO behind one word-address map
// Optional feature macro: DMEM_SW_IRQ_EN (switch rising-edge irq-pending register at IO word 6, irq output)
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata     port A read/write request
//   a_rvalid/a_rdata/a_err        port A response, out-of-range pulse
//   b_req/b_addr                  port B read-only request (RAM only)
//   b_rvalid/b_rdata/b_err        port B response, non-RAM address pulse
//   switches, gpio_in             asynchronous inputs, double-flop synchronised
//   gpio_out                      registered GPIO outputs
//   irq                           OR of pending switch interrupts (DMEM_SW_IRQ_EN only)
module dmem_subsystem #(
   parameter int DATA_W    = 24,
   parameter int ADDR_W    = 19,
   parameter int IO_WORDS  = 76,
   parameter int RAM_WORDS = 65536,
   parameter int GPIO_W    = 36,
   parameter int SW_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_err,
   input  logic              b_req,
   input  logic [ADDR_W-1:0] b_addr,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_err,
   input  logic [SW_W-1:0]   switches,
   input  logic [GPIO_W-1:0] gpio_in,
`ifdef DMEM_SW_IRQ_EN
   output logic              irq,
`endif
   output logic [GPIO_W-1:0] gpio_out
);
   localparam int RAM_AW = $clog2(RAM_WORDS);
   localparam logic [ADDR_W:0] IO_END  = (ADDR_W+1)'(IO_WORDS);
   localparam logic [ADDR_W:0] RAM_END = (ADDR_W+1)'(IO_WORDS + RAM_WORDS);
   logic [DATA_W-1:0] mem [RAM_WORDS];
   logic a_io, a_ram, b_ram, a_rd, a_wr, io_wr, wr3, wr4, wr5;
   logic [RAM_AW-1:0] a_idx, b_idx;
   logic [DATA_W-1:0] io_rd, a_rdata_d, b_rdata_d, a_rdata_q, b_rdata_q, cnt_q, cnt_d;
   logic a_rvalid_q, a_err_q, b_rvalid_q, b_err_q;
   logic [GPIO_W-1:0] gpio_q, gpio_d, gpio_s1_q, gpio_s2_q;
   logic [SW_W-1:0] sw_s1_q, sw_s2_q;
   assign a_io  = {1'b0, a_addr} < IO_END;
   assign a_ram = !a_io && ({1'b0, a_addr} < RAM_END);
   assign b_ram = ({1'b0, b_addr} >= IO_END) && ({1'b0, b_addr} < RAM_END);
   assign a_idx = RAM_AW'(a_addr - ADDR_W'(IO_WORDS));
   assign b_idx = RAM_AW'(b_addr - ADDR_W'(IO_WORDS));
   assign a_rd  = a_req && !a_we;
   assign a_wr  = a_req && a_we;
   assign io_wr = a_wr && a_io;
   assign wr3   = io_wr && (a_addr == ADDR_W'(3));
   assign wr4   = io_wr && (a_addr == ADDR_W'(4));
   assign wr5   = io_wr && (a_addr == ADDR_W'(5));
`ifdef DMEM_SW_IRQ_EN
   logic [SW_W-1:0] sw_s3_q, pend_q, pend_d;
   logic irq_q, wr6;
   assign wr6 = io_wr && (a_addr == ADDR_W'(6));
   // Set has priority over a coinciding write-1-to-clear
   assign pend_d = (pend_q & ~(wr6 ? a_wdata[SW_W-1:0] : '0)) | (sw_s2_q & ~sw_s3_q);
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_s3_q <= '0;
         pend_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         sw_s3_q <= sw_s2_q;
         pend_q  <= pend_d;
         irq_q   <= |pend_d;
      end
   end
   assign irq = irq_q;
`endif
   always_comb begin
      io_rd = '0;
      case (a_addr)
         ADDR_W'(0): io_rd = DATA_W'(sw_s2_q);
         ADDR_W'(1): io_rd = gpio_s2_q[DATA_W-1:0];
         ADDR_W'(2): io_rd = DATA_W'(gpio_s2_q[GPIO_W-1:DATA_W]);
         ADDR_W'(3): io_rd = gpio_q[DATA_W-1:0];
         ADDR_W'(4): io_rd = DATA_W'(gpio_q[GPIO_W-1:DATA_W]);
         ADDR_W'(5): io_rd = cnt_q;
`ifdef DMEM_SW_IRQ_EN
         ADDR_W'(6): io_rd = DATA_W'(pend_q);
`endif
         default:    io_rd = '0;
      endcase
   end
   assign gpio_d    = {wr4 ? a_wdata[GPIO_W-DATA_W-1:0] : gpio_q[GPIO_W-1:DATA_W],
                       wr3 ? a_wdata : gpio_q[DATA_W-1:0]};
   assign cnt_d     = wr5 ? '0 : cnt_q + DATA_W'(1);
   assign a_rdata_d = a_io ? io_rd : a_ram ? mem[a_idx] : '0;
   // Write-first: a same-cycle port A write to the word B reads is forwarded
   assign b_rdata_d = !b_ram ? '0 : (a_wr && a_ram && a_idx == b_idx) ? a_wdata : mem[b_idx];
   always_ff @(posedge clk) begin
      if (a_wr && a_ram) mem[a_idx] <= a_wdata;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         a_rvalid_q <= 1'b0;
         a_err_q    <= 1'b0;
         a_rdata_q  <= '0;
         b_rvalid_q <= 1'b0;
         b_err_q    <= 1'b0;
         b_rdata_q  <= '0;
         gpio_q     <= '0;
         cnt_q      <= '0;
         sw_s1_q    <= '0;
         sw_s2_q    <= '0;
         gpio_s1_q  <= '0;
         gpio_s2_q  <= '0;
      end else begin
         a_rvalid_q <= a_rd;
         a_err_q    <= a_req && !a_io && !a_ram;
         if (a_rd) a_rdata_q <= a_rdata_d;
         b_rvalid_q <= b_req;
         b_err_q    <= b_req && !b_ram;
         if (b_req) b_rdata_q <= b_rdata_d;
         gpio_q     <= gpio_d;
         cnt_q      <= cnt_d;
         sw_s1_q    <= switches;
         sw_s2_q    <= sw_s1_q;
         gpio_s1_q  <= gpio_in;
         gpio_s2_q  <= gpio_s1_q;
      end
   end
   assign a_rvalid = a_rvalid_q;
   assign a_err    = a_err_q;
   assign a_rdata  = a_rdata_q;
   assign b_rvalid = b_rvalid_q;
   assign b_err    = b_err_q;
   assign b_rdata  = b_rdata_q;
   assign gpio_out = gpio_q;
endmodule

// File: tb/tb_dmem_subsystem.sv
// tb_dmem_subsystem: scoreboard bench for dmem_subsystem
module tb_dmem_subsystem;
   logic clk = 1'b0, rst = 1'b1;
   logic a_req, a_we, a_rvalid, a_err, b_req, b_rvalid, b_err;
   logic [18:0] a_addr, b_addr;
   logic [23:0] a_wdata, a_rdata, b_rdata;
   logic [3:0] switches;
   logic [35:0] gpio_in, gpio_out;
`ifdef DMEM_SW_IRQ_EN
   logic irq;
`endif
   typedef struct packed {logic rv; logic err; logic [23:0] d; logic [18:0] addr;} exp_t;
   exp_t qa[$], qb[$];
   int errors = 0, checks = 0;

   dmem_subsystem dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
      .b_req(b_req), .b_addr(b_addr), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
      .switches(switches), .gpio_in(gpio_in),
`ifdef DMEM_SW_IRQ_EN
      .irq(irq),
`endif
      .gpio_out(gpio_out)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin : mon
      exp_t e;
      if (a_rvalid === 1'b1 || a_err === 1'b1) begin
         checks++;
         if (qa.size() == 0) begin
            errors++;
            $display("FAIL a_unexpected got rv=%b err=%b data=%h", a_rvalid, a_err, a_rdata);
         end else begin
            e = qa.pop_front();
            if (a_rvalid !== e.rv || a_err !== e.err || (e.rv && a_rdata !== e.d)) begin
               errors++;
               $display("FAIL a_resp addr=%h got rv=%b err=%b data=%h exp rv=%b err=%b data=%h",
                        e.addr, a_rvalid, a_err, a_rdata, e.rv, e.err, e.d);
            end
         end
      end
      if (b_rvalid === 1'b1 || b_err === 1'b1) begin
         checks++;
         if (qb.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected got rv=%b err=%b data=%h", b_rvalid, b_err, b_rdata);
         end else begin
            e = qb.pop_front();
            if (b_rvalid !== e.rv || b_err !== e.err || b_rdata !== e.d) begin
               errors++;
               $display("FAIL b_resp addr=%h got rv=%b err=%b data=%h exp rv=%b err=%b data=%h",
                        e.addr, b_rvalid, b_err, b_rdata, e.rv, e.err, e.d);
            end
         end
      end
   end

   task automatic cyc(input logic ar, input logic aw, input logic [18:0] aa, input logic [23:0] ad,
                      input logic br, input logic [18:0] ba);
      a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad; b_req = br; b_addr = ba;
      @(posedge clk); #1;
      a_req = 1'b0; a_we = 1'b0; b_req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic a_rd(input logic [18:0] aa, input logic [23:0] d, input logic err);
      qa.push_back(exp_t'{rv: 1'b1, err: err, d: d, addr: aa});
      cyc(1'b1, 1'b0, aa, 24'h0, 1'b0, 19'h0);
   endtask

   task automatic a_wr(input logic [18:0] aa, input logic [23:0] d, input logic err);
      if (err) qa.push_back(exp_t'{rv: 1'b0, err: 1'b1, d: 24'h0, addr: aa});
      cyc(1'b1, 1'b1, aa, d, 1'b0, 19'h0);
   endtask

   task automatic b_rd(input logic [18:0] ba, input logic [23:0] d, input logic err);
      qb.push_back(exp_t'{rv: 1'b1, err: err, d: d, addr: ba});
      cyc(1'b0, 1'b0, 19'h0, 24'h0, 1'b1, ba);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 5 && (qa.size() != 0 || qb.size() != 0); i++) idle(1);
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         errors++;
         $display("FAIL %s_missing_resp got pending a=%0d b=%0d exp 0", name, qa.size(), qb.size());
         qa.delete();
         qb.delete();
      end
   endtask

   function automatic logic [23:0] pat(input int i);
      return 24'(i) * 24'h010101 ^ 24'h0F0F0F;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      idle(2);
      checks++;
      if ({a_rvalid, b_rvalid, a_err, b_err} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags got %b exp 0000", {a_rvalid, b_rvalid, a_err, b_err});
      end
      checks++;
      if (a_rdata !== 24'h0 || b_rdata !== 24'h0) begin
         errors++;
         $display("FAIL reset_rdata got a=%h b=%h exp 0", a_rdata, b_rdata);
      end
      checks++;
      if (gpio_out !== 36'h0) begin
         errors++;
         $display("FAIL reset_gpio got %h exp 0", gpio_out);
      end
      rst = 1'b0;
      a_rd(19'h5, 24'h0, 1'b0);
      a_rd(19'h0, 24'h0, 1'b0);
      drain("reset");
   endtask

   task automatic test_ram();
      a_wr(19'h0004C, 24'h111111, 1'b0);
      a_rd(19'h0004C, 24'h111111, 1'b0);
      a_wr(19'h0004C, 24'h123456, 1'b0);
      a_rd(19'h0004C, 24'h123456, 1'b0);
      a_wr(19'h1004B, 24'h654321, 1'b0);
      a_rd(19'h1004B, 24'h654321, 1'b0);
      a_rd(19'h1004C, 24'h0, 1'b1);
      a_wr(19'h1004C, 24'h777777, 1'b1);
      a_rd(19'h0004B, 24'h0, 1'b0);
      a_rd(19'h0004C, 24'h123456, 1'b0);
      drain("ram");
      checks++;
      if (a_rdata !== 24'h123456) begin
         errors++;
         $display("FAIL rdata_hold got %h exp 123456", a_rdata);
      end
   endtask

   task automatic test_oor();
      a_wr(19'h0FFFF, 24'h5A5A5A, 1'b0);
      a_rd(19'h7FFFF, 24'h0, 1'b1);
      a_wr(19'h7FFFF, 24'h999999, 1'b1);
      a_rd(19'h0FFFF, 24'h5A5A5A, 1'b0);
      drain("oor");
   endtask

   task automatic test_collision();
      qb.push_back(exp_t'{rv: 1'b1, err: 1'b0, d: 24'hABCDEF, addr: 19'h50});
      cyc(1'b1, 1'b1, 19'h00050, 24'hABCDEF, 1'b1, 19'h00050);
      qb.push_back(exp_t'{rv: 1'b1, err: 1'b0, d: 24'hABCDEF, addr: 19'h50});
      cyc(1'b1, 1'b1, 19'h00051, 24'h111222, 1'b1, 19'h00050);
      b_rd(19'h00051, 24'h111222, 1'b0);
      b_rd(19'h00003, 24'h0, 1'b1);
      b_rd(19'h7FFFF, 24'h0, 1'b1);
      b_rd(19'h1004C, 24'h0, 1'b1);
      qa.push_back(exp_t'{rv: 1'b1, err: 1'b0, d: 24'h123456, addr: 19'h4C});
      qb.push_back(exp_t'{rv: 1'b1, err: 1'b0, d: 24'h654321, addr: 19'h1004B});
      cyc(1'b1, 1'b0, 19'h0004C, 24'h0, 1'b1, 19'h1004B);
      drain("collision");
   endtask

   task automatic test_gpio();
      a_wr(19'h4, 24'h000FFF, 1'b0);
      a_wr(19'h3, 24'hFFFFFF, 1'b0);
      checks++;
      if (gpio_out !== 36'hFFFFFFFFF) begin
         errors++;
         $display("FAIL gpio_full got %h exp FFFFFFFFF", gpio_out);
      end
      a_rd(19'h4, 24'h000FFF, 1'b0);
      a_rd(19'h3, 24'hFFFFFF, 1'b0);
      a_wr(19'h4, 24'hABC123, 1'b0);
      checks++;
      if (gpio_out !== 36'h123FFFFFF) begin
         errors++;
         $display("FAIL gpio_upper got %h exp 123FFFFFF", gpio_out);
      end
      a_rd(19'h4, 24'h000123, 1'b0);
      gpio_in = 36'hABCDEF123;
      a_wr(19'h1, 24'h555555, 1'b0);
      idle(1);
      a_rd(19'h1, 24'hDEF123, 1'b0);
      a_rd(19'h2, 24'h000ABC, 1'b0);
      drain("gpio");
   endtask

   task automatic test_sync_counter();
      switches = 4'b1010;
      idle(2);
      a_rd(19'h0, 24'h00000A, 1'b0);
      switches = 4'b0101;
      idle(1);
      a_rd(19'h0, 24'h00000A, 1'b0);
      a_rd(19'h0, 24'h000005, 1'b0);
      a_wr(19'h5, 24'h000123, 1'b0);
      idle(2);
      a_rd(19'h5, 24'h000002, 1'b0);
      a_wr(19'h7, 24'hFFFFFF, 1'b0);
      a_rd(19'h7, 24'h0, 1'b0);
      a_wr(19'h0, 24'hFFFFFF, 1'b0);
      a_rd(19'h0, 24'h000005, 1'b0);
      drain("sync_counter");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) a_wr(19'h100 + 19'(i), pat(i), 1'b0);
      for (int i = 0; i < 8; i++) a_rd(19'h100 + 19'(i), pat(i), 1'b0);
      for (int i = 0; i < 8; i++) b_rd(19'h107 - 19'(i), pat(7 - i), 1'b0);
      drain("back_to_back");
   endtask

   task automatic test_rst_pending();
      switches = 4'b0000;
      rst = 1'b1;
      cyc(1'b1, 1'b0, 19'h0004C, 24'h0, 1'b1, 19'h0004C);
      checks++;
      if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rst_pending_rvalid got a=%b b=%b exp 0", a_rvalid, b_rvalid);
      end
      checks++;
      if (gpio_out !== 36'h0) begin
         errors++;
         $display("FAIL rst_pending_gpio got %h exp 0", gpio_out);
      end
      idle(1);
      rst = 1'b0;
      a_rd(19'h0004C, 24'h123456, 1'b0);
      drain("rst_pending");
   endtask

`ifdef DMEM_SW_IRQ_EN
   task automatic test_irq();
      idle(3);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_idle got %b exp 0", irq);
      end
      switches = 4'b0001;
      idle(4);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_set got %b exp 1", irq);
      end
      a_rd(19'h6, 24'h000001, 1'b0);
      a_wr(19'h6, 24'h000001, 1'b0);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_clear got %b exp 0", irq);
      end
      a_rd(19'h6, 24'h0, 1'b0);
      drain("irq");
   endtask
`endif

   initial begin
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_addr = '0; switches = '0; gpio_in = '0;
      test_reset();
      test_ram();
      test_oor();
      test_collision();
      test_gpio();
      test_sync_counter();
      test_back_to_back();
      test_rst_pending();
`ifdef DMEM_SW_IRQ_EN
      test_irq();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/dmem_subsystem.md
Name: dmem_subsystem

Overview:
- Parametrised second-generation data memory for the 24-bit core.
- Two-port RAM plus a memory-mapped IO register file behind one global word-address map.
- Uniform 1-cycle registered read latency on both regions, with valid strobes.
- Adds out-of-range error reporting, write-first forwarding between ports, input synchronisers and a cycle counter.

Parameters:
- DATA_W, 24, data word width.
- ADDR_W, 19, word-address width of both ports.
- IO_WORDS, 76, size of the IO region at the bottom of the map (words 0..IO_WORDS-1).
- RAM_WORDS, 65536, RAM depth; RAM occupies words IO_WORDS..IO_WORDS+RAM_WORDS-1.
- GPIO_W, 36, GPIO width; constraint DATA_W < GPIO_W <= 2*DATA_W.
- SW_W, 4, switch input width; SW_W <= DATA_W.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  port A access strobe.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  ADDR_W  port A global word address.
- a_wdata  in  DATA_W  port A write data.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  DATA_W  port A read data.
- a_err  out  1  port A out-of-range pulse.
- b_req  in  1  port B read strobe (read-only port).
- b_addr  in  ADDR_W  port B global word address.
- b_rvalid  out  1  port B read data valid.
- b_rdata  out  DATA_W  port B read data.
- b_err  out  1  port B non-RAM address pulse.
- switches  in  SW_W  asynchronous switch inputs.
- gpio_in  in  GPIO_W  asynchronous GPIO inputs.
- gpio_out  out  GPIO_W  registered GPIO outputs.

Behaviour:
- Reset (rst=1 at an edge): a_rvalid, b_rvalid, a_err, b_err, a_rdata, b_rdata, gpio_out, cycle counter and all synchroniser flops go to 0. A read issued in the cycle before reset produces no rvalid. RAM contents are not reset.
- Address decode:
  - addr < IO_WORDS: IO region.
  - IO_WORDS <= addr < IO_WORDS+RAM_WORDS: RAM, physical index addr-IO_WORDS.
  - Anything else: out-of-range.
- Port A read: a_req=1, a_we=0 in cycle N gives a_rvalid=1 and a_rdata in cycle N+1, for both IO and RAM. rvalid is a one-cycle pulse. Back-to-back reads are supported every cycle.
- Port A write: a_req=1, a_we=1 commits at the edge. No rvalid. A read of the same address in the next cycle returns the new data.
- Out-of-range on port A: a_err pulses in N+1. A write is dropped. A read gives a_rvalid=1 with a_rdata=0.
- Port B: reads RAM with the same 1-cycle latency. An IO or out-of-range address gives b_rvalid=1, b_rdata=0 and b_err=1.
- Collision: A writes RAM word X while B reads X in the same cycle. b_rdata returns a_wdata (write-first forwarding).
- IO map (word: function):
  - 0: {0, sw_sync}, read-only.
  - 1: gpio_in_sync[DATA_W-1:0], read-only.
  - 2: {0, gpio_in_sync[GPIO_W-1:DATA_W]}, read-only.
  - 3: gpio_out[DATA_W-1:0], read/write.
  - 4: gpio_out[GPIO_W-1:DATA_W], read/write; upper write bits ignored, read back zero-extended.
  - 5: free-running cycle counter, DATA_W bits, wraps 2^DATA_W-1 -> 0. Any write clears it to 0 at that edge; it increments from the next cycle.
  - 6..IO_WORDS-1: reserved; reads 0, writes ignored, no error.
- Read-only word writes: ignored silently.
- Synchronisers: switches and gpio_in pass through 2-flop synchronisers, so an input change is visible to a read issued 2 cycles later.
- GPIO write timing: gpio_out updates at the write edge; an IO read of word 3 in the next cycle returns the new value.
- Read-data hold: a_rdata and b_rdata hold their last value when rvalid=0.

Optional Feature:
- Macro: DMEM_SW_IRQ_EN.
- Enabled:
  - IO word 6 is an irq-pending register, SW_W bits wide.
  - A bit is set on each rising edge of the corresponding sw_sync bit.
  - Writing 1 to a bit clears it (write-1-to-clear). If a set and a clear coincide, the set wins.
  - Extra output irq (1 bit) = OR of the pending bits, registered; reset value 0.
- Disabled: no irq port; word 6 is reserved as above.

Test Plan:
- Reset, then A reads 0x0004C -> a_rvalid=1 next cycle, RAM index 0 returns the written-earlier value. Write 0x123456 to 0x0004C, read back -> 0x123456.
- A reads 0x7FFFF (out-of-range) -> a_err=1, a_rvalid=1, a_rdata=0. A writes 0x7FFFF -> RAM unchanged.
- Same cycle: A writes 0xABCDEF to 0x00050 and B reads 0x00050 -> b_rdata=0xABCDEF one cycle later.
- A writes 0x000FFF to word 4 and 0xFFFFFF to word 3 -> gpio_out=36'hFFFFFFFFF; read of word 4 returns 0x000FFF.
- switches 4'b0000 -> 4'b1010 at cycle T; A reads word 0 at T+2 -> 0x00000A. Write to word 5, read it 3 cycles later -> 0x000002.
- Assert rst while an A read is pending -> no a_rvalid; gpio_out=0. With DMEM_SW_IRQ_EN, a switch 0->1 sets word 6 bit and irq=1; writing 1 to that bit clears it.
